// File: rtl/lfsr_gen_if.sv
// lfsr_gen_if: control and status bundle for lfsr_gen.
//   load_seed  : load seed_data this cycle (master -> slave)
//   seed_data  : seed value, N bits (master -> slave)
//   enable     : advance one step per cycle (master -> slave)
//   lfsr_data  : current LFSR state (slave -> master)
//   lfsr_done  : one-cycle pulse when the state returns to the captured seed
//   seed_err   : one-cycle pulse when a zero seed was replaced by 1
//   busy       : high while armed or running
//   step_count : steps since last load or wrap
interface lfsr_gen_if #(
    parameter int unsigned N = 8
) ();
    logic         load_seed;
    logic [N-1:0] seed_data;
    logic         enable;
    logic [N-1:0] lfsr_data;
    logic         lfsr_done;
    logic         seed_err;
    logic         busy;
    logic [N-1:0] step_count;

    modport master (
        output load_seed, seed_data, enable,
        input  lfsr_data, lfsr_done, seed_err, busy, step_count
    );

    modport slave (
        input  load_seed, seed_data, enable,
        output lfsr_data, lfsr_done, seed_err, busy, step_count
    );
endinterface

// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised Fibonacci/Galois LFSR with captured seed, zero-seed
// substitution, wrap detection and optional auto-stop.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : lfsr_gen_if.slave (load_seed, seed_data, enable in;
//           lfsr_data, lfsr_done, seed_err, busy, step_count out)
// Optional feature: define LFSR_PERIOD_CNT_EN to build the step counter;
// otherwise step_count is tied to 0.
module lfsr_gen #(
    parameter int unsigned  N         = 8,
    parameter logic [N-1:0] TAPS      = 8'hB8,
    parameter bit           MODE      = 1'b0,
    parameter bit           AUTO_STOP = 1'b0
) (
    input logic       clk,
    input logic       reset,
    lfsr_gen_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StArmed, StRun, StDone} state_e;

    state_e       state_q, state_d;
    logic [N-1:0] q_q;
    logic [N-1:0] seed_q;
    logic [N-1:0] q_next;
    logic [N-1:0] seed_eff;
    logic         done_q;
    logic         err_q;
    logic         step;
    logic         wrap;
    logic         busy;

    always_comb begin
        if (MODE) begin
            q_next = (q_q << 1) ^ (q_q[N-1] ? {TAPS[N-2:0], 1'b1} : '0);
        end else begin
            q_next = {q_q[N-2:0], ^(q_q & TAPS)};
        end
    end

    // A zero seed would lock the register; substitute 1.
    assign seed_eff = (bus.seed_data == '0) ? {{(N-1){1'b0}}, 1'b1} : bus.seed_data;

    // Load wins over enable.
    assign step = bus.enable && !bus.load_seed && (state_q == StArmed || state_q == StRun);
    assign wrap = step && (q_next == seed_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.load_seed) state_d = StArmed;
            end
            StArmed, StRun: begin
                if (bus.load_seed) begin
                    state_d = StArmed;
                end else if (step) begin
                    state_d = (wrap && AUTO_STOP) ? StDone : StRun;
                end
            end
            StDone: begin
                if (bus.load_seed) state_d = StArmed;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy = (state_q == StArmed) || (state_q == StRun);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q    <= '0;
            seed_q <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (bus.load_seed) begin
                q_q    <= seed_eff;
                seed_q <= seed_eff;
                err_q  <= (bus.seed_data == '0);
            end else if (step) begin
                q_q    <= q_next;
                done_q <= wrap;
            end
        end
    end

`ifdef LFSR_PERIOD_CNT_EN
    logic [N-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (bus.load_seed || wrap) begin
            cnt_q <= '0;
        end else if (step) begin
            cnt_q <= cnt_q + N'(1);
        end
    end

    assign bus.step_count = cnt_q;
`else
    assign bus.step_count = '0;
`endif

    assign bus.lfsr_data = q_q;
    assign bus.lfsr_done = done_q;
    assign bus.seed_err  = err_q;
    assign bus.busy      = busy;

endmodule

// File: tb/tb_lfsr_gen.sv
// tb_lfsr_gen: drives three N=4 instances (Fibonacci free-running, Galois
// free-running, Fibonacci auto-stop) with shared stimulus and compares them
// against a model that steps through the known state orbits.
module tb_lfsr_gen;

    logic       clk;
    logic       reset;
    logic       load_seed;
    logic [3:0] seed_data;
    logic       enable;

    int n_checks = 0;
    int n_fail   = 0;

    lfsr_gen_if #(.N(4)) if_fib ();
    lfsr_gen_if #(.N(4)) if_gal ();
    lfsr_gen_if #(.N(4)) if_stop ();

    assign if_fib.load_seed  = load_seed;
    assign if_fib.seed_data  = seed_data;
    assign if_fib.enable     = enable;
    assign if_gal.load_seed  = load_seed;
    assign if_gal.seed_data  = seed_data;
    assign if_gal.enable     = enable;
    assign if_stop.load_seed = load_seed;
    assign if_stop.seed_data = seed_data;
    assign if_stop.enable    = enable;

    lfsr_gen #(.N(4), .TAPS(4'hC), .MODE(1'b0), .AUTO_STOP(1'b0)) u_fib (
        .clk(clk), .reset(reset), .bus(if_fib)
    );
    lfsr_gen #(.N(4), .TAPS(4'hC), .MODE(1'b1), .AUTO_STOP(1'b0)) u_gal (
        .clk(clk), .reset(reset), .bus(if_gal)
    );
    lfsr_gen #(.N(4), .TAPS(4'hC), .MODE(1'b0), .AUTO_STOP(1'b1)) u_stop (
        .clk(clk), .reset(reset), .bus(if_stop)
    );

    logic [3:0] o_data [3];
    logic [3:0] o_cnt  [3];
    logic       o_done [3];
    logic       o_err  [3];
    logic       o_busy [3];

    assign o_data[0] = if_fib.lfsr_data;
    assign o_data[1] = if_gal.lfsr_data;
    assign o_data[2] = if_stop.lfsr_data;
    assign o_cnt[0]  = if_fib.step_count;
    assign o_cnt[1]  = if_gal.step_count;
    assign o_cnt[2]  = if_stop.step_count;
    assign o_done[0] = if_fib.lfsr_done;
    assign o_done[1] = if_gal.lfsr_done;
    assign o_done[2] = if_stop.lfsr_done;
    assign o_err[0]  = if_fib.seed_err;
    assign o_err[1]  = if_gal.seed_err;
    assign o_err[2]  = if_stop.seed_err;
    assign o_busy[0] = if_fib.busy;
    assign o_busy[1] = if_gal.busy;
    assign o_busy[2] = if_stop.busy;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Full orbits of x^4 taps 4'hC starting from 0001.
    logic [3:0] fib_seq [15] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                                 4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
    logic [3:0] gal_seq [15] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h9, 4'hB, 4'hF, 4'h7,
                                 4'hE, 4'h5, 4'hA, 4'hD, 4'h3, 4'h6, 4'hC};
    string      name    [3]  = '{"fib", "gal", "stop"};

    // Model state: 0 idle, 1 armed, 2 run, 3 done.
    int         m_st   [3];
    logic [3:0] m_q    [3];
    logic [3:0] m_seed [3];
    int         m_cnt  [3];
    logic       m_done [3];
    logic       m_err  [3];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] succ(input int k, input logic [3:0] x);
        logic [3:0] t [15];
        if (k == 1) t = gal_seq;
        else        t = fib_seq;
        for (int i = 0; i < 15; i++) begin
            if (t[i] == x) return t[(i + 1) % 15];
        end
        return 4'h0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_st[k] = 0; m_q[k] = 4'h0; m_seed[k] = 4'h0;
            m_cnt[k] = 0; m_done[k] = 1'b0; m_err[k] = 1'b0;
        end
    endtask

    task automatic model_clock(input logic ld, input logic [3:0] sd, input logic en);
        logic [3:0] nq;
        for (int k = 0; k < 3; k++) begin
            m_done[k] = 1'b0;
            m_err[k]  = 1'b0;
            if (ld) begin
                m_q[k]    = (sd == 4'h0) ? 4'h1 : sd;
                m_seed[k] = m_q[k];
                m_err[k]  = (sd == 4'h0);
                m_cnt[k]  = 0;
                m_st[k]   = 1;
            end else if (en && (m_st[k] == 1 || m_st[k] == 2)) begin
                nq     = succ(k, m_q[k]);
                m_q[k] = nq;
                if (nq == m_seed[k]) begin
                    m_done[k] = 1'b1;
                    m_cnt[k]  = 0;
                    m_st[k]   = (k == 2) ? 3 : 2;
                end else begin
                    m_cnt[k] = (m_cnt[k] + 1) % 16;
                    m_st[k]  = 2;
                end
            end
        end
    endtask

    task automatic check_all();
        int exp_cnt;
        for (int k = 0; k < 3; k++) begin
`ifdef LFSR_PERIOD_CNT_EN
            exp_cnt = m_cnt[k];
`else
            exp_cnt = 0;
`endif
            check($sformatf("%s.data", name[k]), 32'(o_data[k]), 32'(m_q[k]));
            check($sformatf("%s.done", name[k]), 32'(o_done[k]), 32'(m_done[k]));
            check($sformatf("%s.err", name[k]), 32'(o_err[k]), 32'(m_err[k]));
            check($sformatf("%s.busy", name[k]), 32'(o_busy[k]),
                  32'(m_st[k] == 1 || m_st[k] == 2));
            check($sformatf("%s.cnt", name[k]), 32'(o_cnt[k]), 32'(exp_cnt));
        end
    endtask

    // Inputs change at the falling edge; outputs are checked one falling edge later.
    task automatic cyc(input logic ld, input logic [3:0] sd, input logic en);
        load_seed = ld;
        seed_data = sd;
        enable    = en;
        @(posedge clk);
        model_clock(ld, sd, en);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        reset     = 1'b0;
        load_seed = 1'b0;
        seed_data = 4'h0;
        enable    = 1'b0;
        model_reset();
        #2;
        check_all();
        @(negedge clk);
        reset = 1'b1;

        // Enable in IDLE is ignored.
        repeat (3) cyc(1'b0, 4'h0, 1'b1);

        // Seed 0001, full period; auto-stop instance then sits in DONE.
        cyc(1'b1, 4'h1, 1'b0);
        repeat (15) cyc(1'b0, 4'h0, 1'b1);
        check("fib.wrapval", 32'(o_data[0]), 32'h1);
        check("stop.idle_busy", 32'(o_busy[2]), 32'h0);
        repeat (4) cyc(1'b0, 4'h0, 1'b1);

        // Zero seed is replaced by 1.
        cyc(1'b1, 4'h0, 1'b0);
        check("zero.subst", 32'(o_data[0]), 32'h1);
        repeat (5) cyc(1'b0, 4'h0, 1'b1);

        // Load and enable together: load wins, no step.
        cyc(1'b1, 4'h8, 1'b1);
        cyc(1'b0, 4'h0, 1'b1);
        check("fib.after8", 32'(o_data[0]), 32'h1);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 19) == 0), 4'($urandom_range(0, 15)),
                ($urandom_range(0, 3) != 0));
        end

        // Asynchronous reset mid-run.
        cyc(1'b1, 4'h1, 1'b0);
        repeat (7) cyc(1'b0, 4'h0, 1'b1);
        enable = 1'b1;
        #2 reset = 1'b0;
        #1;
        model_reset();
        check("rst.data", 32'(o_data[0]), 32'h0);
        check("rst.busy", 32'(o_busy[0]), 32'h0);
        check("rst.done", 32'(o_done[0]), 32'h0);
        @(negedge clk);
        check_all();
        reset = 1'b1;
        repeat (3) cyc(1'b0, 4'h0, 1'b1);
        cyc(1'b1, 4'h5, 1'b0);
        repeat (20) cyc(1'b0, 4'h0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lfsr_gen.md
Name: lfsr_gen

Overview:
Parametrised successor to the team's fixed-table LFSR. Width, tap polynomial and structure (Fibonacci or Galois) are set by parameters. Adds a step enable, a captured seed, zero-seed protection, a wrap-detect state machine with optional auto-stop, and an optional period counter. Used as a pattern and PRBS source for BIST and scrambler blocks.

Parameters:
N, 8, LFSR width; legal range 2..32.
TAPS, 8'hB8, Fibonacci tap mask [N-1:0]; bit i set means q[i] feeds the XOR; bit N-1 must be set.
MODE, 0, 0 = Fibonacci, 1 = Galois.
AUTO_STOP, 0, 1 = halt in DONE after a wrap; 0 = keep running.

Ports:
clk  in  1  clock; all state changes on rising edge.
reset  in  1  asynchronous, active-low reset.
load_seed  in  1  load seed_data this cycle.
seed_data  in  N  seed value.
enable  in  1  advance one step per cycle while high.
lfsr_data  out  N  current LFSR state (registered).
lfsr_done  out  1  one-cycle pulse: state has returned to the captured seed.
seed_err  out  1  one-cycle pulse: zero seed was substituted.
busy  out  1  high in ARMED and RUN.
step_count  out  N  steps since last load or wrap (see Optional Feature).

Behaviour:
- Reset (reset=0, asynchronous): lfsr_data=0, seed_q=0, step_count=0, lfsr_done=0, seed_err=0, busy=0, state=IDLE.
- Fibonacci next state: fb = XOR-reduce(q & TAPS); q_next = {q[N-2:0], fb}.
- Galois next state: GMASK = {TAPS[N-2:0], 1'b1}; q_next = (q << 1) XOR (q[N-1] ? GMASK : 0), truncated to N bits.
- Load: load_seed=1 in any state except IDLE-under-reset gives lfsr_data<=seed_data and seed_q<=seed_data, step_count<=0, state<=ARMED. If seed_data==0, load 1 instead (lfsr_data=seed_q=1) and pulse seed_err for 1 cycle.
- load_seed has priority over enable; a simultaneous enable is ignored, so no step occurs.
- States:
  - IDLE: after reset; enable ignored; lfsr_data holds 0. load_seed goes to ARMED.
  - ARMED: seed loaded, 0 steps taken. enable=1 steps and goes to RUN.
  - RUN: each cycle with enable=1, lfsr_data<=q_next and step_count++. enable=0 holds all state.
  - Wrap: a step whose q_next==seed_q loads lfsr_data<=seed_q and sets lfsr_done=1 on the same edge; the pulse is visible for exactly 1 cycle, coincident with lfsr_data==seed_q. step_count resets to 0 on that edge.
  - After a wrap: if AUTO_STOP=1, go to DONE. If AUTO_STOP=0, stay in RUN and continue stepping.
  - DONE: busy=0; enable ignored; lfsr_data holds the seed. load_seed goes to ARMED.
- lfsr_done never asserts in ARMED; the seed compare is against seed_q, not the live seed_data.
- Zero state is unreachable after a load, so the all-zero lock-up is impossible.
- step_count wraps modulo 2^N; for a maximal polynomial the period of 2^N-1 fits.
- Reset asserted mid-run returns to reset values immediately; no pulse is generated.

Optional Feature:
Macro LFSR_PERIOD_CNT_EN.
- Defined: step_count behaves as described above.
- Undefined: the counter is not built; step_count is tied to 0. All other behaviour is unchanged, including wrap detection, which uses only the compare against seed_q.

Test Plan:
- N=4, TAPS=4'hC, MODE=0, seed 0001, enable held -> lfsr_data 0010,0100,1001,0011,0110,1101,1010,0101,1011,0111,1111,1110,1100,1000,0001. lfsr_done pulses only on the 15th step; step_count 1..14, then 0.
- N=4, TAPS=4'hC, MODE=1, seed 0001 -> 0010,0100,1000,1001,1011,1111,0111,1110,0101,1010,1101,0011,0110,1100,0001. Period 15, lfsr_done on step 15.
- Seed 0000 loaded -> lfsr_data=0001, seed_err pulses 1 cycle, normal sequence follows.
- load_seed and enable high together in RUN, seed 1000 -> lfsr_data=1000, step_count=0, no step. The next enable cycle gives 0001 (N=4, Fibonacci).
- AUTO_STOP=1, N=4: run to wrap -> state DONE, busy=0, further enable leaves lfsr_data=seed. load_seed restarts ARMED with busy=1.
- Reset pulsed low at step 7 -> lfsr_data=0, busy=0, lfsr_done=0 immediately, asynchronously. enable after release is ignored until load_seed.
